// File: rtl/watch_disp_pkg.sv
// Shared display definitions for the watch display path: digit/segment geometry,
// segment bit order and index types.
package watch_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned DISP_W     = NUM_DIGITS * SEG_W;
  localparam int unsigned DIG_W      = 3;
  localparam int unsigned SUB_W      = 3;
  localparam int unsigned NUM_SUBS   = 8;
  localparam int unsigned BRIGHT_W   = 3;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Segment bit positions within a digit byte
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  typedef logic [DIG_W-1:0] dig_idx_t;
  typedef logic [SUB_W-1:0] sub_idx_t;

  // Active-low one-hot anode select for a digit
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input dig_idx_t d);
    return ~(NUM_DIGITS'(1) << d);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the watch core and the scan driver: display word and
// controls in, multiplexed panel pins and frame pulse out.
interface seg_scan_driver_if;
  import watch_disp_pkg::*;

  logic [DISP_W-1:0]     disp_i;
  logic [NUM_DIGITS-1:0] blink_i;
  logic [BRIGHT_W-1:0]   bright_i;
  logic [SEG_W-1:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_o;

  modport master (output disp_i, blink_i, bright_i, input seg_n, an_n, frame_o);
  modport slave  (input disp_i, blink_i, bright_i, output seg_n, an_n, frame_o);

endinterface

// File: rtl/disp_tick_gen.sv
// Scan timing chain: PWM sub-period counter, sub-period index, digit index and
// frame counter with blink phase.
module disp_tick_gen
  import watch_disp_pkg::*;
#(
  parameter int unsigned SUB_DIV      = 6250,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  output sub_idx_t sub_idx,
  output dig_idx_t dig_idx,
  output logic     blink_ph,
  output logic     frame_tick_c
);

  localparam int unsigned SC_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SC_W-1:0] sub_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            sub_tick_c;
  logic            slot_tick_c;

  // Wrap strobes: each stage advances when every stage below it wraps
  always_comb begin
    sub_tick_c   = (sub_cnt == SC_W'(SUB_DIV - 1));
    slot_tick_c  = sub_tick_c && (sub_idx == sub_idx_t'(NUM_SUBS - 1));
    frame_tick_c = slot_tick_c && (dig_idx == dig_idx_t'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt   <= '0;
      sub_idx   <= '0;
      dig_idx   <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      sub_cnt <= sub_tick_c ? '0 : sub_cnt + SC_W'(1);
      if (sub_tick_c) sub_idx <= sub_idx + sub_idx_t'(1);
      if (slot_tick_c)
        dig_idx <= (dig_idx == dig_idx_t'(NUM_DIGITS - 1)) ? '0 : dig_idx + dig_idx_t'(1);
      if (frame_tick_c) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment back-end: tear-free frame shadow, per-digit
// blink and brightness PWM on the anodes, all panel pins registered.
module seg_scan_driver
  import watch_disp_pkg::*;
#(
  parameter int unsigned SUB_DIV      = 6250,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   bus
);

  sub_idx_t          sub_idx;
  dig_idx_t          dig_idx;
  logic              blink_ph;
  logic              frame_tick_c;
  logic [DISP_W-1:0] shadow;
  logic [SEG_W-1:0]  pat_c;
  logic              lit_c;

  disp_tick_gen #(
    .SUB_DIV      (SUB_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .sub_idx      (sub_idx),
    .dig_idx      (dig_idx),
    .blink_ph     (blink_ph),
    .frame_tick_c (frame_tick_c)
  );

  // Current digit pattern and PWM window; sub-period 0 is dead time between digits
  always_comb begin
    pat_c = shadow[SEG_W*dig_idx +: SEG_W];
    if (blink_ph && bus.blink_i[dig_idx]) pat_c = SEG_BLANK;
    lit_c = (sub_idx != '0) && (4'(sub_idx) <= (4'(bus.bright_i) + 4'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_n   <= '1;
      bus.an_n    <= '1;
      bus.frame_o <= 1'b0;
      shadow      <= '0;
    end else begin
      bus.seg_n   <= ~pat_c;
      bus.an_n    <= lit_c ? anode_sel(dig_idx) : '1;
      bus.frame_o <= frame_tick_c;
      if (frame_tick_c) shadow <= bus.disp_i;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-indexed reference model pushes expected pin
// values each clock, a negedge checker pops and compares them.
module tb_seg_scan_driver;
  import watch_disp_pkg::*;

  localparam int unsigned SUB_DIV      = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned SLOT         = SUB_DIV * 8;
  localparam int unsigned FRAME        = SLOT * 6;

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] an;
    logic       fr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_on = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seg_scan_driver_if dif ();

  seg_scan_driver #(
    .SUB_DIV      (SUB_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model indexed by cycles since reset release
  int unsigned m_s;
  int unsigned m_sub, m_dig, m_f;
  logic [47:0] m_sh;
  logic [7:0]  m_pat;
  logic        m_ph;
  exp_t        m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s  = 0;
      m_sh = '0;
    end else begin
      m_sub = (m_s / SUB_DIV) % 8;
      m_dig = (m_s / SLOT) % 6;
      m_f   = m_s / FRAME;
      m_ph  = ((m_f / BLINK_FRAMES) % 2) == 1;
      m_pat = m_sh[8*m_dig +: 8];
      if (m_ph && dif.blink_i[m_dig]) m_pat = 8'h00;
      m_e.seg = ~m_pat;
      m_e.an  = (m_sub >= 1 && m_sub <= dif.bright_i + 1) ? ~(6'b1 << m_dig) : 6'h3F;
      m_e.fr  = ((m_s + 1) % FRAME) == 0;
      if (m_e.fr) m_sh = dif.disp_i;
      q.push_back(m_e);
      m_s++;
    end
  end

  exp_t c_e;
  always @(negedge clk) begin
    if (chk_on) begin
      if (!rst_n) begin
        q.delete();
        chk("rst_seg", 48'(dif.seg_n), 48'hFF);
        chk("rst_an", 48'(dif.an_n), 48'h3F);
        chk("rst_frame", 48'(dif.frame_o), 48'h0);
      end else if (q.size() > 0) begin
        c_e = q.pop_front();
        chk("seg_n", 48'(dif.seg_n), 48'(c_e.seg));
        chk("an_n", 48'(dif.an_n), 48'(c_e.an));
        chk("frame_o", 48'(dif.frame_o), 48'(c_e.fr));
        chk("one_anode", 48'($countones(~dif.an_n) <= 1), 48'h1);
      end
    end
  end

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < int'(FRAME) + 8 && !seen; i++) begin
      @(negedge clk);
      if (dif.frame_o === 1'b1) seen = 1'b1;
    end
    chk("frame_seen", 48'(seen), 48'h1);
  endtask

  task automatic measure(input int exp_low);
    int cnt[6];
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    repeat (FRAME) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) if (dif.an_n[k] === 1'b0) cnt[k]++;
    end
    for (int k = 0; k < 6; k++) chk("lit_clks", 48'(cnt[k]), 48'(exp_low));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bit lit_seen;
    dif.disp_i   = '0;
    dif.blink_i  = '0;
    dif.bright_i = 3'd7;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    // Scan at full brightness
    dif.disp_i = 48'h3F065B4F666D;
    rst_n = 1'b1;
    wait_frame();
    measure(28);

    // Tear-free: new word written while digit 2 is scanning
    wait_frame();
    repeat (2 * SLOT + SLOT / 2) @(negedge clk);
    dif.disp_i = {6{8'hFF}};
    wait_frame();
    repeat (FRAME / 2) @(negedge clk);
    dif.disp_i = 48'h3F065B4F666D;

    // Blink digit 2
    dif.blink_i = 6'b000100;
    repeat (5 * FRAME) @(negedge clk);

    // Brightness extremes
    dif.bright_i = 3'd0;
    repeat (2) @(negedge clk);
    measure(4);
    dif.bright_i = 3'd3;
    repeat (2) @(negedge clk);
    measure(16);

    // Async reset while a digit is lit
    lit_seen = 1'b0;
    for (int i = 0; i < int'(SLOT) * 2 && !lit_seen; i++) begin
      @(negedge clk);
      if (dif.an_n !== 6'h3F) lit_seen = 1'b1;
    end
    chk("lit_before_rst", 48'(lit_seen), 48'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", 48'(dif.seg_n), 48'hFF);
    chk("async_an", 48'(dif.an_n), 48'h3F);
    chk("async_frame", 48'(dif.frame_o), 48'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME + 8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
